// File: rtl/ivs_ahb_mst.sv
// Single-transfer AHB-Lite initiator: turns a valid/ready register command into one
// NONSEQ word transfer and returns read data / error status on a valid/ready response.
module ivs_ahb_mst #(
    parameter int         TOUT_W    = 8,
    parameter int         TOUT_MAX  = 255,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        hclk,
    input  logic        hrst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_tout,
    output logic        busy,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);
    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ADDR  | address phase, NONSEQ on the bus until hready
    // DATA  | data phase, hwdata held until hready
    // RESP  | response held on rsp_* until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    // Abort on the edge that samples the TOUT_MAX-th consecutive low hready cycle.
    localparam logic [TOUT_W-1:0] CNT_LAST = TOUT_W'(TOUT_MAX - 1);

    state_t             state_q, state_d;
    logic [TOUT_W-1:0]  cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         htrans_d;
    logic               hwrite_d;
    logic [31:0]        haddr_d, hwdata_d, rdata_d;
    logic               rerr_d, rtout_d;
    logic               tout_hit, resp_bad;

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign tout_hit  = (cnt_q == CNT_LAST);
    assign resp_bad  = (hresp != 2'b00);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        htrans_d = htrans;
        hwrite_d = hwrite;
        haddr_d  = haddr;
        hwdata_d = hwdata;
        rdata_d  = rsp_rdata;
        rerr_d   = rsp_err;
        rtout_d  = rsp_tout;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d  = S_ADDR;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = cmd_write;
                    haddr_d  = cmd_addr & 32'hFFFF_FFFC;
                    wdata_d  = cmd_wdata;
                    cnt_d    = '0;
                end
            end
            S_ADDR: begin
                if (hready) begin
                    state_d  = S_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    cnt_d    = '0;
                end else if (tout_hit) begin
                    state_d  = S_RESP;
                    htrans_d = HTRANS_IDLE;
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rtout_d  = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + TOUT_W'(1);
                end
            end
            S_DATA: begin
                if (resp_bad) err_d = 1'b1;
                if (hready) begin
                    state_d = S_RESP;
                    rdata_d = hwrite ? 32'h0 : hrdata;
                    rerr_d  = err_q | resp_bad;
                    rtout_d = 1'b0;
                    cnt_d   = '0;
                end else if (tout_hit) begin
                    state_d = S_RESP;
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    rtout_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TOUT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            htrans    <= HTRANS_IDLE;
            hwrite    <= 1'b0;
            haddr     <= '0;
            hwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tout  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            htrans    <= htrans_d;
            hwrite    <= hwrite_d;
            haddr     <= haddr_d;
            hwdata    <= hwdata_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= rerr_d;
            rsp_tout  <= rtout_d;
        end
    end
endmodule

// File: tb/tb_ivs_ahb_mst.sv
// Bench for ivs_ahb_mst: table of transfers with a scripted slave, response scoreboard,
// plus hand-written back-to-back and asynchronous-reset sequences.
module tb_ivs_ahb_mst;
    localparam int TOUT = 4;

    logic        hclk = 1'b0;
    logic        hrst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_tout, busy;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    ivs_ahb_mst #(.TOUT_W(8), .TOUT_MAX(TOUT), .HPROT_VAL(4'b0011)) dut (
        .hclk(hclk), .hrst_n(hrst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tout(rsp_tout), .busy(busy),
        .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        int          bp;
        logic        err;
        logic        tout;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tout;
    } rsp_t;

    rsp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic run_txn(input txn_t t, input string nm);
        int          lat;
        int          ndp;
        logic [31:0] ea;
        rsp_t        e;
        ea = t.addr & 32'hFFFF_FFFC;
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata;
        hready = 1'b1; hresp = 2'b00;
        chk(cmd_ready, 1, {nm, "_cmd_ready"});
        e.rdata = (t.write || t.tout) ? 32'h0 : t.rdata;
        e.err   = t.err | t.tout;
        e.tout  = t.tout;
        sb.push_back(e);
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        for (int i = 0; i <= t.aw; i++) begin
            @(negedge hclk); lat++;
            chk(htrans, 2'b10, {nm, "_addr_htrans"});
            chk(haddr, ea, {nm, "_haddr"});
            chk(hwrite, t.write, {nm, "_hwrite"});
            hready = (i == t.aw);
        end
        ndp = t.tout ? TOUT : t.dw + 1;
        for (int i = 0; i < ndp; i++) begin
            @(negedge hclk); lat++;
            chk(htrans, 2'b00, {nm, "_data_htrans"});
            if (t.write) chk(hwdata, t.wdata, {nm, "_hwdata"});
            hready = !t.tout && (i == t.dw);
            hresp  = (t.err && i >= ndp - 2) ? 2'b01 : 2'b00;
            hrdata = (i == ndp - 1) ? t.rdata : (32'hBAD0_0000 | 32'(i));
        end
        @(negedge hclk); lat++;
        hready = 1'b1; hresp = 2'b00;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) break;
            @(negedge hclk); lat++;
        end
        chk(rsp_valid, 1, {nm, "_rsp_valid"});
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk(lat, t.tout ? 2 + t.aw + TOUT : 3 + t.aw + t.dw, {nm, "_latency"});
            chk(rsp_rdata, e.rdata, {nm, "_rsp_rdata"});
            chk(rsp_err, e.err, {nm, "_rsp_err"});
            chk(rsp_tout, e.tout, {nm, "_rsp_tout"});
            chk(htrans, 2'b00, {nm, "_resp_htrans"});
            chk(busy, 1, {nm, "_resp_busy"});
            for (int j = 0; j < t.bp; j++) begin
                @(negedge hclk);
                chk(rsp_valid, 1, {nm, "_bp_valid"});
                chk(rsp_rdata, e.rdata, {nm, "_bp_rdata"});
                chk({rsp_err, rsp_tout}, {e.err, e.tout}, {nm, "_bp_status"});
                chk(cmd_ready, 0, {nm, "_bp_cmd_ready"});
            end
        end
        rsp_ready = 1'b1;
        @(posedge hclk); #1;
        rsp_ready = 1'b0;
        @(negedge hclk);
        chk({rsp_valid, cmd_ready, busy}, 3'b010, {nm, "_after_hs"});
    endtask

    txn_t tbl[8];
    rsp_t e2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hrst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; hready = 1'b1; hresp = 2'b00; hrdata = '0;
        //          write  addr           wdata          rdata          aw dw bp err   tout
        tbl[0] = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0, 0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0200, 32'h0,         32'h1234_5678, 0, 1, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_010F, 32'h0000_55AA, 32'h0,         2, 0, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0300, 32'hA0A0_0001, 32'h0,         0, 1, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0008, 32'h0,         32'h5555_5555, 0, 0, 0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,         32'hA5A5_0040, 0, 0, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h0,         1, 2, 5, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0FFE, 32'h0,         32'h8765_4321, 1, 3, 2, 1'b0, 1'b0};

        repeat (2) @(negedge hclk);
        chk({htrans, hwrite, rsp_valid, rsp_err, rsp_tout, busy}, 7'b0, "reset_ctrl");
        chk(haddr | hwdata | rsp_rdata, 32'h0, "reset_data");
        chk(cmd_ready, 1, "reset_cmd_ready");
        hrst_n = 1'b1;
        @(negedge hclk);
        chk({hsize, hburst, hprot}, {3'b010, 3'b000, 4'b0011}, "const_outputs");

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("t%0d", i));

        // Back-to-back: second command waits through RESP and the IDLE cycle.
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10F; cmd_wdata = 32'h1111_2222;
        hready = 1'b1; hresp = 2'b00;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        @(posedge hclk); #1;
        cmd_write = 1'b0; cmd_addr = 32'h200;
        @(negedge hclk);
        chk(htrans, 2'b10, "b2b_first_nonseq");
        chk(haddr, 32'h10C, "b2b_align");
        chk(cmd_ready, 0, "b2b_busy_addr");
        @(negedge hclk);
        chk(htrans, 2'b00, "b2b_first_data");
        chk(hwdata, 32'h1111_2222, "b2b_hwdata");
        sb.push_back('{32'hCAFE_F00D, 1'b0, 1'b0});
        @(negedge hclk);
        chk({rsp_valid, cmd_ready}, 2'b10, "b2b_first_rsp");
        e2 = sb.pop_front();
        chk({rsp_err, rsp_tout}, {e2.err, e2.tout}, "b2b_first_status");
        rsp_ready = 1'b1;
        @(posedge hclk); #1;
        rsp_ready = 1'b0;
        @(negedge hclk);
        chk({htrans, cmd_ready, rsp_valid}, 4'b0010, "b2b_idle_gap");
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        @(negedge hclk);
        chk(htrans, 2'b10, "b2b_second_nonseq");
        chk({haddr, hwrite}, {32'h200, 1'b0}, "b2b_second_addr");
        hrdata = 32'hCAFE_F00D;
        @(negedge hclk);
        @(negedge hclk);
        chk(rsp_valid, 1, "b2b_second_rsp");
        e2 = sb.pop_front();
        chk(rsp_rdata, e2.rdata, "b2b_second_rdata");
        rsp_ready = 1'b1;
        @(posedge hclk); #1;
        rsp_ready = 1'b0;

        // Asynchronous reset while the address phase is stalled.
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_wdata = 32'h77;
        hready = 1'b0;
        @(posedge hclk); #1;
        cmd_valid = 1'b0;
        @(negedge hclk);
        chk({htrans, busy}, 3'b101, "rst_pre_addr");
        chk(haddr, 32'h500, "rst_pre_haddr");
        #2 hrst_n = 1'b0;
        #1;
        chk({htrans, hwrite, rsp_valid, rsp_err, rsp_tout, busy}, 7'b0, "rst_async_ctrl");
        chk(haddr | hwdata | rsp_rdata, 32'h0, "rst_async_data");
        chk(cmd_ready, 1, "rst_async_cmd_ready");
        @(negedge hclk);
        hrst_n = 1'b1; hready = 1'b1;
        @(negedge hclk);
        chk({cmd_ready, busy, htrans}, 4'b1000, "rst_released_idle");

        run_txn(tbl[1], "post_rst");
        chk(sb.size(), 0, "sb_empty");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
